acc_demo_table_loader: RTL

- Sequences the acc-demo particle table into the acc-demo encode memory from a host word stream (W/X encode pairs).
- Publishes the particle count and the acc-demo mode enable to the acc-demo controller.
- Blocks table rewrites while a scan is running.
- Drains the skip-record FIFO into a valid/ready report stream for the host.

---
 rtl/acc_demo_table_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/acc_demo_table_loader.sv
// Loads the acc-demo particle table from a host W/X word stream into the encode memory,
// publishes particle count and mode to the controller, and drains skip records to the host.
module acc_demo_table_loader #(
    parameter int unsigned MAX_PARTICLE = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_start_i,
    input  logic        mode_clear_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [31:0] cfg_data_i,
    input  logic        cfg_last_i,
    input  logic        pmt_scan_en_i,
    output logic        acc_demo_wren_o,
    output logic [15:0] acc_demo_addr_o,
    output logic [31:0] acc_demo_Wencode_o,
    output logic [31:0] acc_demo_Xencode_o,
    output logic [15:0] acc_demo_particle_cnt_o,
    output logic        acc_demo_mode_o,
    output logic        load_busy_o,
    output logic        load_err_o,
    input  logic        skip_fifo_ready_i,
    output logic        skip_fifo_rd_o,
    input  logic [63:0] skip_fifo_data_i,
    output logic        report_valid_o,
    input  logic        report_ready_i,
    output logic [63:0] report_data_o
);
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, ARMED, ERR} state_t;

    state_t            state;
    logic [CNT_W-1:0]  entry_cnt;
    logic [WORD_W-1:0] w_word;
    logic              rd_pending;
    logic              start_ok;
    logic              clear_ok;
    logic              cfg_fire;

    // Host commands only take effect while no scan is running.
    assign start_ok = load_start_i & ~pmt_scan_en_i;
    assign clear_ok = mode_clear_i & ~pmt_scan_en_i;
    assign cfg_fire = cfg_valid_i & cfg_ready_o;

    // Load sequencer; cfg_ready/load_busy are registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state                   <= IDLE;
            entry_cnt               <= '0;
            w_word                  <= '0;
            cfg_ready_o             <= 1'b0;
            load_busy_o             <= 1'b0;
            acc_demo_wren_o         <= 1'b0;
            acc_demo_addr_o         <= '0;
            acc_demo_Wencode_o      <= '0;
            acc_demo_Xencode_o      <= '0;
            acc_demo_particle_cnt_o <= '0;
            acc_demo_mode_o         <= 1'b0;
            load_err_o              <= 1'b0;
        end else begin
            acc_demo_wren_o <= 1'b0;
            unique case (state)
                IDLE, ARMED, ERR: begin
                    // A start beats a simultaneous clear in ARMED.
                    if (start_ok) begin
                        state           <= LOAD_W;
                        entry_cnt       <= '0;
                        load_err_o      <= 1'b0;
                        acc_demo_mode_o <= 1'b0;
                        cfg_ready_o     <= 1'b1;
                        load_busy_o     <= 1'b1;
                    end else if (state == ARMED && clear_ok) begin
                        state           <= IDLE;
                        acc_demo_mode_o <= 1'b0;
                    end
                end
                LOAD_W: begin
                    if (cfg_fire) begin
                        w_word <= cfg_data_i;
                        if (cfg_last_i) begin
                            state                   <= ERR;
                            load_err_o              <= 1'b1;
                            acc_demo_mode_o         <= 1'b0;
                            acc_demo_particle_cnt_o <= '0;
                            cfg_ready_o             <= 1'b0;
                            load_busy_o             <= 1'b0;
                        end else begin
                            state <= LOAD_X;
                        end
                    end
                end
                LOAD_X: begin
                    if (cfg_fire) begin
                        // Table full: the extra pair is dropped and the load fails.
                        if (entry_cnt == CNT_W'(MAX_PARTICLE)) begin
                            state                   <= ERR;
                            load_err_o              <= 1'b1;
                            acc_demo_mode_o         <= 1'b0;
                            acc_demo_particle_cnt_o <= '0;
                            cfg_ready_o             <= 1'b0;
                            load_busy_o             <= 1'b0;
                        end else begin
                            acc_demo_wren_o    <= 1'b1;
                            acc_demo_addr_o    <= entry_cnt;
                            acc_demo_Wencode_o <= w_word;
                            acc_demo_Xencode_o <= cfg_data_i;
                            entry_cnt          <= entry_cnt + CNT_W'(1);
                            if (cfg_last_i) begin
                                state                   <= ARMED;
                                acc_demo_particle_cnt_o <= entry_cnt + CNT_W'(1);
                                acc_demo_mode_o         <= 1'b1;
                                cfg_ready_o             <= 1'b0;
                                load_busy_o             <= 1'b0;
                            end else begin
                                state <= LOAD_W;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Skip drain: one read in flight at a time; data is captured the cycle after the pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            skip_fifo_rd_o <= 1'b0;
            rd_pending     <= 1'b0;
            report_valid_o <= 1'b0;
            report_data_o  <= '0;
        end else begin
            skip_fifo_rd_o <= 1'b0;
            if (report_valid_o && report_ready_i) begin
                report_valid_o <= 1'b0;
            end
            if (rd_pending && !skip_fifo_rd_o) begin
                report_data_o  <= skip_fifo_data_i;
                report_valid_o <= 1'b1;
                rd_pending     <= 1'b0;
            end else if (skip_fifo_ready_i && !rd_pending &&
                         (!report_valid_o || report_ready_i)) begin
                skip_fifo_rd_o <= 1'b1;
                rd_pending     <= 1'b1;
            end
        end
    end
endmodule
